// File: rtl/ysyx_23060020_pkg.sv
// ysyx_23060020_pkg
// Shared definitions for the multi-cycle RV32I-subset core:
//   - opcode and funct3 encodings for the supported instructions
//   - sequencing FSM state enum
//   - halt-cause codes reported on the halt_cause output
//   - the EBREAK instruction word
package ysyx_23060020_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;

    localparam logic [2:0] F3_ADD  = 3'b000;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        FETCH,
        IWAIT,
        EXEC,
        MREQ,
        MWAIT,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EBREAK   = 2'd1,
        CAUSE_ILLEGAL  = 2'd2,
        CAUSE_MISALIGN = 2'd3
    } halt_cause_t;

endpackage

// File: rtl/ysyx_23060020_mc_core_if.sv
// ysyx_23060020_mc_core_if
// Bus bundle between the core and its memories.
//   Fetch channel : if_req_valid/if_req_addr/if_req_ready, if_rsp_valid/if_rsp_inst
//   Load/store    : ls_req_valid/ls_req_wen/ls_req_addr/ls_req_wdata/ls_req_wmask/ls_req_ready,
//                   ls_rsp_valid/ls_rsp_rdata
// Modports: master = core side, slave = memory side.
interface ysyx_23060020_mc_core_if;

    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;

    logic        ls_req_valid;
    logic        ls_req_wen;
    logic [31:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic [3:0]  ls_req_wmask;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_rdata;

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_inst,
        output ls_req_valid, ls_req_wen, ls_req_addr, ls_req_wdata, ls_req_wmask,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata
    );

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_inst,
        input  ls_req_valid, ls_req_wen, ls_req_addr, ls_req_wdata, ls_req_wmask,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata
    );

endinterface

// File: rtl/ysyx_23060020_lsu_align.sv
// ysyx_23060020_lsu_align
// Combinational lane handling for byte/half/word accesses.
//   funct3     in  load/store width (and sign for loads)
//   addr_lo    in  low two bits of the byte address
//   wen        in  1 = store; strobes are forced to zero for loads
//   store_data in  raw rs2 value
//   rdata      in  aligned 32-bit word returned by memory
//   wmask      out byte strobes
//   wdata      out store data replicated across all lanes
//   load_data  out extracted and sign/zero-extended load result
module ysyx_23060020_lsu_align
    import ysyx_23060020_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        wen,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Store side: replicate the datum into every lane so memory only
    // needs the strobes to pick the right bytes.
    always_comb begin
        wmask = 4'b0000;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                wmask = 4'b0001 << addr_lo;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: wmask = 4'b1111;
        endcase
        if (!wen) begin
            wmask = 4'b0000;
        end
    end

    // Load side: select the addressed lane and extend to 32 bits.
    always_comb begin
        case (addr_lo)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  load_data = {24'd0, byte_lane};
            F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  load_data = {16'd0, half_lane};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060020_rf.sv
// ysyx_23060020_rf
// General-purpose register file, two async read ports, one sync write port.
//   NR_REGS   32 (RV32I) or 16 (RV32E); anything else stops elaboration
//   raddr1/2  in  read indices, rdata1/2 out (x0 always reads zero)
//   we/waddr/wdata in  write port, writes to x0 are discarded
// Registers are deliberately not reset.
module ysyx_23060020_rf #(
    parameter int NR_REGS = 32
) (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    localparam int AW = $clog2(NR_REGS);

    generate
        if (NR_REGS != 32 && NR_REGS != 16) begin : g_bad_nr_regs
            $error("ysyx_23060020_rf: NR_REGS must be 16 or 32");
        end
    endgenerate

    logic [31:0] regs [NR_REGS];

    // Write port; the decoder rejects out-of-range indices for RV32E, so
    // only the low AW bits are needed here.
    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0) begin
            regs[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1[AW-1:0]];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2[AW-1:0]];

endmodule

// File: rtl/ysyx_23060020_mc_core.sv
// ysyx_23060020_mc_core
// Multi-cycle RV32I-subset core with valid/ready fetch and load/store channels.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        ysyx_23060020_mc_core_if.master (fetch + load/store channels)
//   pc         current PC
//   halt       sticky stop indication
//   halt_cause 0 none, 1 ebreak, 2 illegal, 3 misaligned
// Optional: define YSYX_23060020_COMMIT_EN to add commit_valid/commit_pc/
// commit_inst/commit_rd/commit_wdata retirement outputs.
module ysyx_23060020_mc_core
    import ysyx_23060020_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NR_REGS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    ysyx_23060020_mc_core_if.master bus,
    output logic [31:0] pc,
    output logic        halt,
    output logic [1:0]  halt_cause
`ifdef YSYX_23060020_COMMIT_EN
    ,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [31:0] commit_inst,
    output logic [4:0]  commit_rd,
    output logic [31:0] commit_wdata
`endif
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    halt_cause_t cause_q, cause_d;
    logic [31:0] inst_q;
    logic [31:0] ls_addr_q;
    logic [31:0] ls_data_q;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;

    logic        legal, is_ebreak, is_load, is_store;
    logic        uses_rd, uses_rs1, uses_rs2, reg_oob, illegal;
    logic        taken;
    logic [31:0] target, wb_data, mem_addr;
    logic        mem_misalign, jump_misalign;

    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [3:0]  align_wmask;
    logic [31:0] align_wdata, align_load;

    assign opcode = inst_q[6:0];
    assign rd     = inst_q[11:7];
    assign f3     = inst_q[14:12];
    assign rs1    = inst_q[19:15];
    assign rs2    = inst_q[24:20];
    assign f7     = inst_q[31:25];

    assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
    assign imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
    assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign imm_u = {inst_q[31:12], 12'd0};
    assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

    ysyx_23060020_rf #(
        .NR_REGS(NR_REGS)
    ) u_rf (
        .clk   (clk),
        .raddr1(rs1),
        .raddr2(rs2),
        .rdata1(rs1_val),
        .rdata2(rs2_val),
        .we    (rf_we),
        .waddr (rd),
        .wdata (rf_wdata)
    );

    ysyx_23060020_lsu_align u_align (
        .funct3    (f3),
        .addr_lo   (ls_addr_q[1:0]),
        .wen       (is_store),
        .store_data(ls_data_q),
        .rdata     (bus.ls_rsp_rdata),
        .wmask     (align_wmask),
        .wdata     (align_wdata),
        .load_data (align_load)
    );

    // Decode and execute. inst_q and the register file stay constant from
    // EXEC until the instruction retires, so these results remain valid
    // through MREQ/MWAIT as well.
    always_comb begin
        legal     = 1'b0;
        is_ebreak = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        uses_rd   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        taken     = 1'b0;
        target    = pc_q + imm_b;
        wb_data   = 32'd0;
        case (opcode)
            OP_LUI: begin
                legal = 1'b1; uses_rd = 1'b1;
                wb_data = imm_u;
            end
            OP_AUIPC: begin
                legal = 1'b1; uses_rd = 1'b1;
                wb_data = pc_q + imm_u;
            end
            OP_JAL: begin
                legal = 1'b1; uses_rd = 1'b1; taken = 1'b1;
                wb_data = pc_q + 32'd4;
                target  = pc_q + imm_j;
            end
            OP_JALR: begin
                legal = (f3 == 3'b000); uses_rd = 1'b1; uses_rs1 = 1'b1; taken = 1'b1;
                wb_data = pc_q + 32'd4;
                target  = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; legal = 1'b1;
                case (f3)
                    F3_BEQ:  taken = (rs1_val == rs2_val);
                    F3_BNE:  taken = (rs1_val != rs2_val);
                    F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
                    F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
                    F3_BLTU: taken = (rs1_val <  rs2_val);
                    F3_BGEU: taken = (rs1_val >= rs2_val);
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                is_load = 1'b1; uses_rd = 1'b1; uses_rs1 = 1'b1;
                legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                        (f3 == F3_LBU) || (f3 == F3_LHU);
            end
            OP_STORE: begin
                is_store = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
            end
            OP_IMM: begin
                legal = (f3 == F3_ADD); uses_rd = 1'b1; uses_rs1 = 1'b1;
                wb_data = rs1_val + imm_i;
            end
            OP_REG: begin
                legal = (f3 == F3_ADD) && (f7 == 7'd0);
                uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                wb_data = rs1_val + rs2_val;
            end
            OP_SYSTEM: begin
                is_ebreak = (inst_q == INST_EBREAK);
                legal     = is_ebreak;
            end
            default: legal = 1'b0;
        endcase
    end

    // RV32E has no x16..x31; touching one is treated as an illegal instruction.
    assign reg_oob = (NR_REGS == 16) &&
                     ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]));
    assign illegal = !legal || reg_oob;

    assign mem_addr      = rs1_val + (is_store ? imm_s : imm_i);
    assign mem_misalign  = (is_load || is_store) &&
                           (((f3[1:0] == 2'b01) && mem_addr[0]) ||
                            ((f3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00)));
    assign jump_misalign = taken && (target[1:0] != 2'b00);

    // Sequencing FSM: next state, PC, halt cause and register writeback.
    // Halting instructions leave PC and rd untouched.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cause_d  = cause_q;
        rf_we    = 1'b0;
        rf_wdata = wb_data;
        case (state_q)
            FETCH: if (bus.if_req_ready) state_d = IWAIT;
            IWAIT: if (bus.if_rsp_valid) state_d = EXEC;
            EXEC: begin
                if (illegal) begin
                    state_d = HALT;
                    cause_d = CAUSE_ILLEGAL;
                end else if (is_ebreak) begin
                    state_d = HALT;
                    cause_d = CAUSE_EBREAK;
                end else if (mem_misalign || jump_misalign) begin
                    state_d = HALT;
                    cause_d = CAUSE_MISALIGN;
                end else if (is_load || is_store) begin
                    state_d = MREQ;
                end else begin
                    rf_we   = uses_rd;
                    pc_d    = taken ? target : pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            MREQ: if (bus.ls_req_ready) state_d = MWAIT;
            MWAIT: begin
                if (bus.ls_rsp_valid) begin
                    rf_we    = is_load;
                    rf_wdata = align_load;
                    pc_d     = pc_q + 32'd4;
                    state_d  = FETCH;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // State register with synchronous reset; any outstanding request is
    // dropped by returning to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    // Datapath capture: instruction word on fetch response, and the memory
    // address/store data at EXEC so the request stays stable while stalled.
    always_ff @(posedge clk) begin
        if (state_q == IWAIT && bus.if_rsp_valid) begin
            inst_q <= bus.if_rsp_inst;
        end
        if (state_q == EXEC) begin
            ls_addr_q <= mem_addr;
            ls_data_q <= rs2_val;
        end
    end

    assign bus.if_req_valid = (state_q == FETCH) && !rst;
    assign bus.if_req_addr  = pc_q;
    assign bus.ls_req_valid = (state_q == MREQ) && !rst;
    assign bus.ls_req_wen   = is_store;
    assign bus.ls_req_addr  = ls_addr_q;
    assign bus.ls_req_wdata = align_wdata;
    assign bus.ls_req_wmask = align_wmask;

    assign pc         = pc_q;
    assign halt       = (state_q == HALT);
    assign halt_cause = cause_q;

`ifdef YSYX_23060020_COMMIT_EN
    assign commit_valid = !rst && (((state_q == EXEC) && (state_d == FETCH)) ||
                                   ((state_q == MWAIT) && bus.ls_rsp_valid));
    assign commit_pc    = pc_q;
    assign commit_inst  = inst_q;
    assign commit_rd    = rf_we ? rd : 5'd0;
    assign commit_wdata = rf_we ? rf_wdata : 32'd0;
`endif

endmodule
